// File: rtl/uart_cfg_pkg.sv
// rtl/uart_cfg_pkg.sv - shared UART configuration byte layout, address and state encoding
// Imported by the config master and the config register block so the byte format lives in one place.
package uart_cfg_pkg;

  localparam logic [1:0] CFG_ADDR  = 2'b01;
  localparam logic [1:0] IDLE_ADDR = 2'b00;

  localparam int STOP_WE  = 6;
  localparam int PAR_WE   = 5;
  localparam int STOP_BIT = 4;
  localparam int PAR_LSB  = 2;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } cfg_state_e;

  // A field whose write-enable is clear carries zero code bits.
  function automatic logic [7:0] encode_cfg(
    input logic       stop_we,
    input logic       par_we,
    input logic       stop,
    input logic [1:0] par
  );
    logic [7:0] b;
    b                = 8'h00;
    b[STOP_WE]       = stop_we;
    b[PAR_WE]        = par_we;
    b[STOP_BIT]      = stop & stop_we;
    b[PAR_LSB +: 2]  = par & {2{par_we}};
    return b;
  endfunction

endpackage

// File: rtl/uart_config_master_if.sv
// rtl/uart_config_master_if.sv - host request, config write bus and status signals of the config master
interface uart_config_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_parity_en;
  logic [1:0] req_parity;
  logic       req_stop_en;
  logic       req_stop;
  logic       c_valid;
  logic [1:0] c_addr;
  logic [7:0] c_data;
  logic       c_ready;
  logic       busy;
  logic       boot_done;
  logic       err;
  logic       err_clr;

  modport master (
    input  req_valid, req_parity_en, req_parity, req_stop_en, req_stop, c_ready, err_clr,
    output req_ready, c_valid, c_addr, c_data, busy, boot_done, err
  );

  modport slave (
    output req_valid, req_parity_en, req_parity, req_stop_en, req_stop, c_ready, err_clr,
    input  req_ready, c_valid, c_addr, c_data, busy, boot_done, err
  );
endinterface

// File: rtl/uart_config_master.sv
// rtl/uart_config_master.sv - writes the default UART config after reset, then serves host set-parity/stop requests
// One write in flight at a time; a write without c_ready for TIMEOUT_CYCLES cycles is abandoned and flagged in err.
module uart_config_master
  import uart_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [1:0]  DEFAULT_PARITY = PAR_NONE,
  parameter logic        DEFAULT_STOP   = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  uart_config_master_if.master bus
);

  localparam int unsigned   CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  cfg_state_e    r_state,     w_state;
  logic          r_c_valid,   w_c_valid;
  logic [1:0]    r_c_addr,    w_c_addr;
  logic [7:0]    r_c_data,    w_c_data;
  logic          r_req_ready, w_req_ready;
  logic          r_busy,      w_busy;
  logic          r_boot_done, w_boot_done;
  logic          r_boot_flag, w_boot_flag;
  logic          r_err,       w_err;
  logic [CW-1:0] r_cnt,       w_cnt;
  logic          w_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_BOOT;
      r_c_valid   <= 1'b0;
      r_c_addr    <= IDLE_ADDR;
      r_c_data    <= 8'h00;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b1;
      r_boot_done <= 1'b0;
      r_boot_flag <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_c_valid   <= w_c_valid;
      r_c_addr    <= w_c_addr;
      r_c_data    <= w_c_data;
      r_req_ready <= w_req_ready;
      r_busy      <= w_busy;
      r_boot_done <= w_boot_done;
      r_boot_flag <= w_boot_flag;
      r_err       <= w_err;
      r_cnt       <= w_cnt;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_c_valid   = r_c_valid;
    w_c_addr    = r_c_addr;
    w_c_data    = r_c_data;
    w_req_ready = r_req_ready;
    w_busy      = r_busy;
    w_boot_done = r_boot_done;
    w_boot_flag = r_boot_flag;
    w_err       = r_err & ~bus.err_clr;
    w_cnt       = r_cnt;
    w_done      = 1'b0;

    case (r_state)
      ST_BOOT: begin
        w_state     = ST_WRITE;
        w_c_valid   = 1'b1;
        w_c_addr    = CFG_ADDR;
        w_c_data    = encode_cfg(1'b1, 1'b1, DEFAULT_STOP, DEFAULT_PARITY);
        w_req_ready = 1'b0;
        w_busy      = 1'b1;
        w_boot_flag = 1'b1;
        w_cnt       = '0;
      end

      ST_IDLE: begin
        w_req_ready = 1'b1;
        w_busy      = 1'b0;
        // A request with no field enabled is consumed without touching the bus.
        if (bus.req_valid && r_req_ready && (bus.req_parity_en || bus.req_stop_en)) begin
          w_state     = ST_WRITE;
          w_c_valid   = 1'b1;
          w_c_addr    = CFG_ADDR;
          w_c_data    = encode_cfg(bus.req_stop_en, bus.req_parity_en,
                                   bus.req_stop, bus.req_parity);
          w_req_ready = 1'b0;
          w_busy      = 1'b1;
          w_boot_flag = 1'b0;
          w_cnt       = '0;
        end
      end

      ST_WRITE: begin
        if (r_c_valid && bus.c_ready) begin
          w_done = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          // Timeout set takes priority over a simultaneous err_clr.
          w_done = 1'b1;
          w_err  = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end

        if (w_done) begin
          w_state     = ST_IDLE;
          w_c_valid   = 1'b0;
          w_c_addr    = IDLE_ADDR;
          w_c_data    = 8'h00;
          w_req_ready = 1'b1;
          w_busy      = 1'b0;
          w_boot_done = r_boot_done | r_boot_flag;
          w_boot_flag = 1'b0;
          w_cnt       = '0;
        end
      end

      default: begin
        w_state = ST_BOOT;
      end
    endcase
  end

  assign bus.c_valid   = r_c_valid;
  assign bus.c_addr    = r_c_addr;
  assign bus.c_data    = r_c_data;
  assign bus.req_ready = r_req_ready;
  assign bus.busy      = r_busy;
  assign bus.boot_done = r_boot_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_uart_config_master.sv
// tb/tb_uart_config_master.sv - self-checking bench for uart_config_master
// A transaction-level model predicts the outputs every cycle; directed literals pin key values.
module tb_uart_config_master;
  import uart_cfg_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_config_master_if bus_if();

  uart_config_master #(
    .TIMEOUT_CYCLES(TO),
    .DEFAULT_PARITY(PAR_NONE),
    .DEFAULT_STOP  (1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] req_byte(input bit pen, input bit [1:0] par, input bit sen, input bit stp);
    int v;
    v = 0;
    if (sen) v = v + 64;
    if (pen) v = v + 32;
    if (sen && stp) v = v + 16;
    if (pen) v = v + 4 * int'(par);
    return 8'(v);
  endfunction

  bit         m_pending, m_active, m_boot_wr, m_boot_done, m_err;
  logic [7:0] m_byte;
  int         m_wait;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pending   <= 1'b1;
      m_active    <= 1'b0;
      m_boot_wr   <= 1'b0;
      m_boot_done <= 1'b0;
      m_err       <= 1'b0;
      m_byte      <= 8'h00;
      m_wait      <= 0;
    end else begin
      if (m_active && !bus_if.c_ready && m_wait + 1 >= TO) m_err <= 1'b1;
      else if (bus_if.err_clr) m_err <= 1'b0;

      if (m_pending) begin
        m_pending <= 1'b0;
        m_active  <= 1'b1;
        m_byte    <= req_byte(1'b1, PAR_NONE, 1'b1, 1'b0);
        m_boot_wr <= 1'b1;
        m_wait    <= 0;
      end else if (m_active) begin
        if (bus_if.c_ready || m_wait + 1 >= TO) begin
          m_active <= 1'b0;
          m_wait   <= 0;
          if (m_boot_wr) m_boot_done <= 1'b1;
          m_boot_wr <= 1'b0;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (bus_if.req_valid && (bus_if.req_parity_en || bus_if.req_stop_en)) begin
        m_active  <= 1'b1;
        m_byte    <= req_byte(bus_if.req_parity_en, bus_if.req_parity,
                              bus_if.req_stop_en, bus_if.req_stop);
        m_boot_wr <= 1'b0;
        m_wait    <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("c_valid",   32'(bus_if.c_valid),   32'(m_active));
    chk("c_addr",    32'(bus_if.c_addr),    m_active ? 32'h1 : 32'h0);
    chk("c_data",    32'(bus_if.c_data),    m_active ? 32'(m_byte) : 32'h0);
    chk("req_ready", 32'(bus_if.req_ready), 32'(!m_active && !m_pending));
    chk("busy",      32'(bus_if.busy),      32'(m_active || m_pending));
    chk("boot_done", 32'(bus_if.boot_done), 32'(m_boot_done));
    chk("err",       32'(bus_if.err),       32'(m_err));
    chk("ready_and_valid", 32'(bus_if.req_ready & bus_if.c_valid), 32'h0);
  end

  int run = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (bus_if.c_valid) run <= run + 1;
    else begin
      if (run != 0) last_run <= run;
      run <= 0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fall(input int maxc);
    for (int i = 0; i < maxc && bus_if.c_valid; i++) step();
    chk("wait_bound", 32'(bus_if.c_valid), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end

  initial begin
    bus_if.req_valid     = 1'b0;
    bus_if.req_parity_en = 1'b0;
    bus_if.req_parity    = 2'b00;
    bus_if.req_stop_en   = 1'b0;
    bus_if.req_stop      = 1'b0;
    bus_if.c_ready       = 1'b1;
    bus_if.err_clr       = 1'b0;

    step(); step();
    chk("rst_c_valid",   32'(bus_if.c_valid),   32'h0);
    chk("rst_c_data",    32'(bus_if.c_data),    32'h00);
    chk("rst_busy",      32'(bus_if.busy),      32'h1);
    chk("rst_req_ready", 32'(bus_if.req_ready), 32'h0);
    chk("rst_boot_done", 32'(bus_if.boot_done), 32'h0);
    rst = 1'b1;

    step();
    chk("boot_valid", 32'(bus_if.c_valid), 32'h1);
    chk("boot_addr",  32'(bus_if.c_addr),  32'h1);
    chk("boot_data",  32'(bus_if.c_data),  32'h60);
    step();
    chk("boot_fall",      32'(bus_if.c_valid),   32'h0);
    chk("boot_done_set",  32'(bus_if.boot_done), 32'h1);
    chk("boot_req_ready", 32'(bus_if.req_ready), 32'h1);
    chk("boot_err",       32'(bus_if.err),       32'h0);

    bus_if.req_valid = 1'b1; bus_if.req_parity_en = 1'b1; bus_if.req_parity = PAR_EVEN;
    bus_if.req_stop_en = 1'b0; bus_if.req_stop = 1'b0; bus_if.c_ready = 1'b0;
    step();
    bus_if.req_valid = 1'b0;
    chk("par_data_c1", 32'(bus_if.c_data), 32'h28);
    step(); step(); step();
    chk("par_data_c4", 32'(bus_if.c_data), 32'h28);
    bus_if.c_ready = 1'b1;
    step();
    chk("par_fall",    32'(bus_if.c_valid),   32'h0);
    chk("par_ready",   32'(bus_if.req_ready), 32'h1);
    chk("par_run_len", 32'(last_run),         32'd4);

    bus_if.req_valid = 1'b1; bus_if.req_parity_en = 1'b0; bus_if.req_stop_en = 1'b1; bus_if.req_stop = 1'b1;
    step();
    chk("stop_data", 32'(bus_if.c_data), 32'h50);
    bus_if.req_parity_en = 1'b1; bus_if.req_parity = PAR_ODD; bus_if.req_stop_en = 1'b0;
    step();
    chk("b2b_gap_valid", 32'(bus_if.c_valid),   32'h0);
    chk("b2b_gap_ready", 32'(bus_if.req_ready), 32'h1);
    step();
    bus_if.req_valid = 1'b0;
    chk("b2b_data", 32'(bus_if.c_data), 32'h24);
    step();
    chk("b2b_run_len", 32'(last_run), 32'd1);

    bus_if.req_valid = 1'b1; bus_if.req_parity_en = 1'b0; bus_if.req_stop_en = 1'b0;
    step();
    bus_if.req_valid = 1'b0;
    chk("noop_valid", 32'(bus_if.c_valid),   32'h0);
    chk("noop_ready", 32'(bus_if.req_ready), 32'h1);
    step();

    bus_if.c_ready = 1'b0;
    bus_if.req_valid = 1'b1; bus_if.req_stop_en = 1'b1; bus_if.req_stop = 1'b0;
    step();
    bus_if.req_valid = 1'b0;
    chk("to_data", 32'(bus_if.c_data), 32'h40);
    wait_fall(40);
    chk("to_run_len", 32'(last_run),   32'd16);
    chk("to_err",     32'(bus_if.err), 32'h1);

    bus_if.err_clr = 1'b1;
    step();
    bus_if.err_clr = 1'b0;
    chk("err_cleared", 32'(bus_if.err), 32'h0);

    bus_if.req_valid = 1'b1; bus_if.req_stop = 1'b1;
    step();
    bus_if.req_valid = 1'b0;
    repeat (15) step();
    bus_if.err_clr = 1'b1;
    step();
    bus_if.err_clr = 1'b0;
    chk("set_wins_err",   32'(bus_if.err),     32'h1);
    chk("set_wins_fall",  32'(bus_if.c_valid), 32'h0);
    chk("set_wins_run",   32'(last_run),       32'd16);

    bus_if.req_valid = 1'b1; bus_if.req_parity_en = 1'b1; bus_if.req_parity = PAR_ODD;
    bus_if.req_stop_en = 1'b1; bus_if.req_stop = 1'b0;
    step();
    bus_if.req_valid = 1'b0;
    chk("mid_data", 32'(bus_if.c_data), 32'h64);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus_if.c_valid), 32'h0);
    chk("mid_rst_busy",  32'(bus_if.busy),    32'h1);
    step();
    rst = 1'b1;
    step();
    chk("reboot_valid", 32'(bus_if.c_valid), 32'h1);
    chk("reboot_data",  32'(bus_if.c_data),  32'h60);
    bus_if.c_ready = 1'b1;
    step();
    chk("reboot_done", 32'(bus_if.boot_done), 32'h1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
